// File: rtl/pdm_pkg.sv
// Shared constants and saturation helpers for the PCM-to-PDM output path.
// Optional build macro: PCM_TO_PDM_DITHER_EN (LFSR dither ahead of the comparator).
package pdm_pkg;

  localparam int PCM_W = 16;
  localparam int I1_W  = 20;
  localparam int I2_W  = 24;
  // Working width for integrator sums: i2 + i1 - fb never exceeds 25 bits plus sign.
  localparam int ACC_W = 26;

  localparam logic signed [PCM_W-1:0] FB_POS = 16'sh7FFF;
  localparam logic signed [PCM_W-1:0] FB_NEG = -16'sh8000;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic signed [ACC_W-1:0] I1_MAX = 26'sd524287;
  localparam logic signed [ACC_W-1:0] I1_MIN = -26'sd524288;
  localparam logic signed [ACC_W-1:0] I2_MAX = 26'sd8388607;
  localparam logic signed [ACC_W-1:0] I2_MIN = -26'sd8388608;

  // Clamp a wide signed sum into the 20-bit first integrator.
  function automatic logic signed [I1_W-1:0] sat20(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] c;
    if (v > I1_MAX)      c = I1_MAX;
    else if (v < I1_MIN) c = I1_MIN;
    else                 c = v;
    return c[I1_W-1:0];
  endfunction

  // Clamp a wide signed sum into the 24-bit second integrator.
  function automatic logic signed [I2_W-1:0] sat24(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] c;
    if (v > I2_MAX)      c = I2_MAX;
    else if (v < I2_MIN) c = I2_MIN;
    else                 c = v;
    return c[I2_W-1:0];
  endfunction

endpackage

// File: rtl/sigma_delta_mod2.sv
// Second-order sigma-delta modulator stepped once per PDM bit.
// Optional build macro: PCM_TO_PDM_DITHER_EN adds a 4-bit LFSR dither at the
// comparator input only; integrator state never sees the dither.
module sigma_delta_mod2
  import pdm_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [PCM_W-1:0] x,
  output logic                    pdm
);

  logic signed [I1_W-1:0]  i1_q, i1_d;
  logic signed [I2_W-1:0]  i2_q, i2_d;
  logic                    pdm_q, pdm_d;
  logic signed [PCM_W-1:0] fb;
  logic signed [ACC_W-1:0] fb_x, x_x, i1_x, i2_x, sum1, sum2, cmp;
  logic signed [ACC_W-1:0] dither_x;

`ifdef PCM_TO_PDM_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Next LFSR state and the sign-extended low nibble used as dither (-8..+7).
  always_comb begin
    lfsr_d   = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    dither_x = {{(ACC_W-4){lfsr_q[3]}}, lfsr_q[3:0]};
  end

  // LFSR advances with the modulator; reset reloads the seed.
  always_ff @(posedge clk) begin
    if (rst)     lfsr_q <= LFSR_SEED;
    else if (en) lfsr_q <= lfsr_d;
  end
`else
  assign dither_x = '0;
`endif

  // Integrator updates: i2 accumulates the old i1, both subtract the same feedback.
  always_comb begin
    fb    = pdm_q ? FB_POS : FB_NEG;
    fb_x  = ACC_W'(fb);
    x_x   = ACC_W'(x);
    i1_x  = ACC_W'(i1_q);
    i2_x  = ACC_W'(i2_q);
    sum1  = i1_x + x_x - fb_x;
    sum2  = i2_x + i1_x - fb_x;
    i1_d  = sat20(sum1);
    i2_d  = sat24(sum2);
    cmp   = ACC_W'(i2_d) + dither_x;
    pdm_d = ~cmp[ACC_W-1];
  end

  // Modulator state only moves on the bit strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      i1_q  <= '0;
      i2_q  <= '0;
      pdm_q <= 1'b0;
    end else if (en) begin
      i1_q  <= i1_d;
      i2_q  <= i2_d;
      pdm_q <= pdm_d;
    end
  end

  assign pdm = pdm_q;

endmodule

// File: rtl/pcm_to_pdm.sv
// PCM-to-PDM converter: one-entry sample buffer, bit/frame counters, PDM bit
// clock and underrun/overrun flags around a second-order sigma-delta modulator.
// Optional build macro: PCM_TO_PDM_DITHER_EN (see sigma_delta_mod2).
//
// Input handshake: pcm_valid is a one-cycle strobe with no back-pressure; d_in
// is captured on every cycle pcm_valid is high. A strobe landing on a full
// buffer overwrites it (overrun) unless the same cycle is a frame boundary, in
// which case the old entry moves to the modulator and the new one takes its place.
module pcm_to_pdm
  import pdm_pkg::*;
#(
  parameter int CLK_DIV = 50,  // even, >= 4
  parameter int OSR     = 64   // power of two, 16..256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [PCM_W-1:0] d_in,
  input  logic                    pcm_valid,
  output logic                    pdm_out,
  output logic                    pdm_clk,
  output logic                    underrun,
  output logic                    overrun
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(OSR);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(OSR - 1);

  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic                    pdm_clk_q, pdm_clk_d;
  logic signed [PCM_W-1:0] buf_q, buf_d;
  logic                    buf_full_q, buf_full_d;
  logic signed [PCM_W-1:0] cur_q, cur_d;
  logic                    underrun_q, underrun_d;
  logic                    overrun_q, overrun_d;
  logic                    bit_stb, frame_stb;

  // Counters, bit clock and the one-entry sample buffer.
  always_comb begin
    bit_stb   = (div_cnt_q == DIV_LAST);
    frame_stb = bit_stb && (bit_cnt_q == BIT_LAST);

    div_cnt_d = bit_stb ? '0 : div_cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    if (bit_stb) bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;

    // Low for the first half of each bit period so the rising edge sits mid-bit.
    pdm_clk_d = (div_cnt_d >= DIV_HALF);

    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    cur_d      = cur_q;
    underrun_d = 1'b0;
    overrun_d  = 1'b0;

    if (frame_stb) begin
      if (buf_full_q) begin
        cur_d      = buf_q;
        buf_full_d = pcm_valid;
        if (pcm_valid) buf_d = d_in;
      end else begin
        // Nothing to load: keep playing the previous sample.
        underrun_d = 1'b1;
        if (pcm_valid) begin
          buf_d      = d_in;
          buf_full_d = 1'b1;
        end
      end
    end else if (pcm_valid) begin
      buf_d      = d_in;
      buf_full_d = 1'b1;
      overrun_d  = buf_full_q;
    end
  end

  // Register all control state; reset abandons any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      pdm_clk_q  <= 1'b0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      cur_q      <= '0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      pdm_clk_q  <= pdm_clk_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      cur_q      <= cur_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
    end
  end

  // The modulator sees cur_d so a sample loaded at a frame boundary drives the
  // very first bit of the new frame.
  sigma_delta_mod2 u_mod (
    .clk (clk),
    .rst (rst),
    .en  (bit_stb),
    .x   (cur_d),
    .pdm (pdm_out)
  );

  assign pdm_clk  = pdm_clk_q;
  assign underrun = underrun_q;
  assign overrun  = overrun_q;

endmodule

// File: doc/pcm_to_pdm.md
Name: pcm_to_pdm

Overview:
Output-side counterpart of the microphone path: converts the 16-bit signed PCM stream leaving the bandpass cascade back into a 1-bit PDM stream for a speaker/amplifier pin.
- Accepts PCM samples on a valid strobe and buffers one sample.
- Holds each sample for OSR PDM bits and runs a second-order sigma-delta modulator at the PDM bit rate.
- Generates the matching PDM bit clock.

Parameters:
CLK_DIV, 50, system clock cycles per PDM bit; even, >= 4 (100 MHz / 50 = 2 MHz PDM)
OSR, 64, PDM bits per PCM sample; power of two, 16..256

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
d_in  input  16  signed PCM sample, two's complement
pcm_valid  input  1  one-cycle strobe; d_in valid this cycle
pdm_out  output  1  PDM data bit
pdm_clk  output  1  PDM bit clock, period CLK_DIV cycles
underrun  output  1  one-cycle pulse: frame boundary with no new sample buffered
overrun  output  1  one-cycle pulse: buffered sample overwritten before use

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: pdm_out=0, pdm_clk=0, underrun=0, overrun=0.
  - State: div_cnt=0, bit_cnt=0, buf empty, cur=0, i1=0, i2=0, LFSR=seed.
  - Reset mid-frame: the whole frame is abandoned and no flags fire.
- div_cnt counts 0..CLK_DIV-1 and wraps. bit_stb is high when div_cnt==CLK_DIV-1.
- pdm_clk is registered: 0 while div_cnt < CLK_DIV/2, 1 otherwise. pdm_out changes only on the cycle after bit_stb, so the rising edge of pdm_clk is mid-bit.
- bit_cnt increments on bit_stb and wraps at OSR-1. frame_stb = bit_stb && bit_cnt==OSR-1.
- Sample buffer (one entry, buf + buf_full):
  - pcm_valid with buf empty: buf<=d_in, buf_full<=1.
  - pcm_valid with buf_full and no frame_stb: buf<=d_in, overrun pulses next cycle.
  - frame_stb with buf_full: cur<=buf. If pcm_valid is also high, buf<=d_in and buf_full stays 1, with no overrun. Otherwise buf_full<=0.
  - frame_stb with buf empty: cur holds its value and underrun pulses next cycle.
- Modulator, updated on bit_stb only:
  - fb = pdm_out ? +32767 : -32768.
  - i1 <= sat20(i1 + cur - fb).
  - i2 <= sat24(i2 + i1 - fb), using the old i1.
  - pdm_out <= (i2_next + dither) >= 0.
  - All arithmetic is signed. Saturation clamps to the max/min of the target width; there is no wrap.
- Stable input range is |d_in| <= 0x6000. Larger inputs are accepted but rely on integrator saturation.
- Latency: a sample accepted before frame_stb affects pdm_out starting at the first bit of the next frame.
- PDM ones density is approximately (cur + 32768) / 65536.

Optional Feature:
PCM_TO_PDM_DITHER_EN
- Defined:
  - A 16-bit Fibonacci LFSR runs with taps 16,14,13,11 and seed 0xACE1, advancing on bit_stb.
  - dither = sign-extended lfsr[3:0] (range -8..+7), added before the comparator only. Integrator state is unaffected.
  - Reset reloads the seed.
- Undefined: dither = 0 and no LFSR logic is instantiated.

Decomposition:
- Package pdm_pkg:
  - PCM_W=16, I1_W=20, I2_W=24.
  - FB_POS=16'sh7FFF, FB_NEG=-16'sh8000.
  - LFSR_SEED=16'hACE1 and the tap mask.
  - sat helper functions.
- Sub-module sigma_delta_mod2:
  - Contains the integrators, feedback, optional dither and comparator.
  - Inputs: clk, rst, en(bit_stb), x(cur). Output: pdm bit.
  - Top level keeps the counters, buffer, pdm_clk and flags.

Test Plan:
- CLK_DIV=4, OSR=16, no input: pdm_clk toggles every 2 cycles (period 4). underrun pulses once every 64 cycles. pdm_out density is 50%, i.e. 8 +/-1 ones per 16 bits after 4 settling frames.
- OSR=64, d_in=0x6000 presented once per frame: after 4 frames, 56 +/-2 ones per 64 bits. d_in=-0x6000 gives 8 +/-2 ones. No underrun or overrun.
- Two pcm_valid strobes (0x1000, then 0x2000) in one frame: overrun pulses once. The next frame's cur equals 0x2000.
- pcm_valid coincident with frame_stb while buf_full: cur takes the old buf, buf takes the new d_in, and overrun stays 0.
- rst asserted at bit_cnt=20 mid-frame: the next cycle shows all outputs 0 and counters 0. No underrun at the interrupted boundary. The first pdm_out update occurs CLK_DIV cycles after rst deasserts.
- With PCM_TO_PDM_DITHER_EN and d_in=0 over 1024 bits: density is 50% +/-2%, and the pdm_out sequence differs from the undithered build.
